// File: rtl/matrix_inverter.sv
// rtl/matrix_inverter.sv - sequential 3x3 sign-magnitude matrix inverter (cofactor / determinant / restoring divide)
// Optional MATRIX_INVERTER_ROUND_EN: round quotients to nearest instead of truncating.
module matrix_inverter #(
    parameter int MSIZE = 9,
    parameter int FBITS = 7
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MSIZE-1:0] M00,
    input  logic [MSIZE-1:0] M01,
    input  logic [MSIZE-1:0] M02,
    input  logic [MSIZE-1:0] M10,
    input  logic [MSIZE-1:0] M11,
    input  logic [MSIZE-1:0] M12,
    input  logic [MSIZE-1:0] M20,
    input  logic [MSIZE-1:0] M21,
    input  logic [MSIZE-1:0] M22,
    output logic             busy,
    output logic             done,
    output logic             singular,
    output logic [MSIZE-1:0] I00,
    output logic [MSIZE-1:0] I01,
    output logic [MSIZE-1:0] I02,
    output logic [MSIZE-1:0] I10,
    output logic [MSIZE-1:0] I11,
    output logic [MSIZE-1:0] I12,
    output logic [MSIZE-1:0] I20,
    output logic [MSIZE-1:0] I21,
    output logic [MSIZE-1:0] I22
);
    localparam int TW  = MSIZE + 1;
    localparam int CW  = 2 * (MSIZE - 1) + 2;
    localparam int DW  = 3 * (MSIZE - 1) + 3;
    localparam int QW  = MSIZE - 1;
    localparam int WW  = DW + MSIZE;
    localparam int CYW = $clog2(MSIZE);
    localparam logic [CYW-1:0] LAST = CYW'(MSIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COF, S_DET, S_SGCK, S_DIV, S_DONE} state_t;

    state_t state, state_next;

    logic [MSIZE-1:0]       m_in  [9];
    logic [MSIZE-1:0]       m_reg [9];
    logic signed [TW-1:0]   m_tc  [9];
    logic signed [CW-1:0]   cof   [9];
    logic [MSIZE-1:0]       res   [9];
    logic [MSIZE-1:0]       i_reg [9];
    logic signed [CW-1:0]   tmp;
    logic signed [DW-1:0]   det;
    logic [4:0]             step;
    logic [1:0]             row, col;
    logic [CYW-1:0]         cyc;
    logic [WW-1:0]          rem, dsh;
    logic [QW-1:0]          q;
    logic                   sat, qsign;

    logic [1:0]             r1, r2, c1, c2;
    logic signed [DW-1:0]   mul_a, mul_b, prod;
    logic signed [CW-1:0]   cnum;
    logic [CW-1:0]          cmag;
    logic [DW-1:0]          dmag;
    logic [WW-1:0]          n_full, dlim;
    logic                   ge;
    logic [QW-1:0]          q_next;
    logic [MSIZE-1:0]       res_word;

    function automatic logic [1:0] inc3(input logic [1:0] r);
        return (r == 2'd2) ? 2'd0 : r + 2'd1;
    endfunction

    function automatic logic [3:0] at(input logic [1:0] r, input logic [1:0] c);
        return {2'b00, r} + {2'b00, r} + {2'b00, r} + {2'b00, c};
    endfunction

    function automatic logic signed [DW-1:0] sext_tc(input logic signed [TW-1:0] v);
        return {{(DW-TW){v[TW-1]}}, v};
    endfunction

    function automatic logic signed [DW-1:0] sext_cof(input logic signed [CW-1:0] v);
        return {{(DW-CW){v[CW-1]}}, v};
    endfunction

    assign m_in[0] = M00;
    assign m_in[1] = M01;
    assign m_in[2] = M02;
    assign m_in[3] = M10;
    assign m_in[4] = M11;
    assign m_in[5] = M12;
    assign m_in[6] = M20;
    assign m_in[7] = M21;
    assign m_in[8] = M22;

    assign I00 = i_reg[0];
    assign I01 = i_reg[1];
    assign I02 = i_reg[2];
    assign I10 = i_reg[3];
    assign I11 = i_reg[4];
    assign I12 = i_reg[5];
    assign I20 = i_reg[6];
    assign I21 = i_reg[7];
    assign I22 = i_reg[8];

    // Cyclic row/column indexing gives the cofactor sign for free in 3x3.
    always_comb begin
        r1    = inc3(row);
        r2    = inc3(r1);
        c1    = inc3(col);
        c2    = inc3(c1);
        mul_a = '0;
        mul_b = '0;
        if (state == S_DET) begin
            mul_a = sext_tc(m_tc[at(2'd0, step[1:0])]);
            mul_b = sext_cof(cof[at(2'd0, step[1:0])]);
        end else begin
            mul_a = sext_tc(m_tc[at(r1, step[0] ? c2 : c1)]);
            mul_b = sext_tc(m_tc[at(r2, step[0] ? c1 : c2)]);
        end
    end

    assign prod = mul_a * mul_b;

    always_comb begin
        cnum = cof[at(col, row)];
        cmag = cnum[CW-1] ? -cnum : cnum;
        dmag = det[DW-1] ? -det : det;
`ifdef MATRIX_INVERTER_ROUND_EN
        n_full = {{(WW-CW-2*FBITS){1'b0}}, cmag, {(2*FBITS){1'b0}}}
               + {{(WW-DW+1){1'b0}}, dmag[DW-1:1]};
`else
        n_full = {{(WW-CW-2*FBITS){1'b0}}, cmag, {(2*FBITS){1'b0}}};
`endif
        dlim     = {{(WW-DW-QW){1'b0}}, dmag, {QW{1'b0}}};
        ge       = rem >= dsh;
        q_next   = sat ? q : {q[QW-2:0], ge};
        res_word = {qsign & (|q_next), q_next};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_COF;
            S_COF:  if (step == 5'd17) state_next = S_DET;
            S_DET:  if (step == 5'd2) state_next = S_SGCK;
            S_SGCK: state_next = (det == '0) ? S_DONE : S_DIV;
            S_DIV:  if (cyc == LAST && row == 2'd2 && col == 2'd2) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                m_reg[k] <= '0;
                m_tc[k]  <= '0;
                cof[k]   <= '0;
                res[k]   <= '0;
                i_reg[k] <= '0;
            end
            tmp      <= '0;
            det      <= '0;
            step     <= '0;
            row      <= '0;
            col      <= '0;
            cyc      <= '0;
            rem      <= '0;
            dsh      <= '0;
            q        <= '0;
            sat      <= 1'b0;
            qsign    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) for (int k = 0; k < 9; k++) m_reg[k] <= m_in[k];
                end
                S_LOAD: begin
                    for (int k = 0; k < 9; k++)
                        m_tc[k] <= m_reg[k][MSIZE-1] ? -$signed({2'b00, m_reg[k][MSIZE-2:0]})
                                                     :  $signed({2'b00, m_reg[k][MSIZE-2:0]});
                    det  <= '0;
                    step <= '0;
                    row  <= '0;
                    col  <= '0;
                    cyc  <= '0;
                end
                S_COF: begin
                    if (!step[0]) begin
                        tmp <= prod[CW-1:0];
                    end else begin
                        cof[at(row, col)] <= tmp - prod[CW-1:0];
                        col <= inc3(col);
                        if (col == 2'd2) row <= inc3(row);
                    end
                    step <= (step == 5'd17) ? 5'd0 : step + 5'd1;
                end
                S_DET: begin
                    det  <= det + prod;
                    step <= step + 5'd1;
                end
                S_DIV: begin
                    // First cycle screens for overflow; the rest shift out one quotient bit each.
                    if (cyc == '0) begin
                        qsign <= cnum[CW-1] ^ det[DW-1];
                        if (n_full >= dlim) begin
                            sat <= 1'b1;
                            q   <= '1;
                        end else begin
                            sat <= 1'b0;
                            rem <= n_full;
                            dsh <= dlim >> 1;
                            q   <= '0;
                        end
                    end else begin
                        if (!sat && ge) rem <= rem - dsh;
                        dsh <= dsh >> 1;
                        q   <= q_next;
                    end
                    if (cyc == LAST) begin
                        res[at(row, col)] <= res_word;
                        cyc <= '0;
                        col <= inc3(col);
                        if (col == 2'd2) row <= inc3(row);
                    end else begin
                        cyc <= cyc + CYW'(1);
                    end
                end
                default: ;
            endcase
            if (state_next == S_DONE) begin
                singular <= (det == '0);
                for (int k = 0; k < 9; k++) begin
                    if (det == '0)
                        i_reg[k] <= '0;
                    else if (state == S_DIV && 4'(k) == at(row, col))
                        i_reg[k] <= res_word;
                    else
                        i_reg[k] <= res[k];
                end
            end
        end
    end
endmodule
